serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial adder controller: time-multiplexes one full-adder cell over
//   WIDTH bit positions, one bit per clock, LSB first. Replaces the WIDTH-cell
//   ripple chain where area matters. Sits between switch/operand registers and
//   the LED display logic. Start/busy/done handshake with the requester.
// PARAMETERS
//   WIDTH  4  operand width in bits (>=2); sum is WIDTH bits plus cout
// PORTS
//   clk    in   1      system clock, rising edge
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request; sampled only in IDLE
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry-in, captured on accepted start
//   busy   out  1      high while state==RUN
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  result bits; held until next completion
//   cout   out  1      carry-out; held until next completion
// BEHAVIOUR
//   Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0,
//     operand shift regs, carry reg and bit counter cleared.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0 -> latch a,b into shift regs, cin into carry reg,
//     counter=0, go RUN. start=0 -> stay IDLE.
//   RUN: each edge E1..E_WIDTH: s=a0^b0^c, c'=a0&b0|a0&c|b0&c on current LSBs;
//     shift s into result reg (MSB-in, right shift), shift operands right,
//     carry reg=c', counter+1. At E_WIDTH (counter==WIDTH-1): go DONE, copy
//     result reg to sum and final carry to cout in the same edge.
//   DONE: done=1 for exactly one cycle; next edge -> IDLE unconditionally.
//   Latency: done high in the cycle after edge E_WIDTH, i.e. WIDTH cycles
//     after the accepting edge; minimum start-to-start period WIDTH+2 cycles.
//   busy=1 exactly during RUN (WIDTH cycles); done and busy never both high.
//   start while RUN or DONE: ignored, no effect on operands or result.
//   a, b, cin changing after acceptance: no effect on current operation.
//   sum/cout change only on the DONE-entry edge or reset; stable otherwise.
//   Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
//   Counter width clog2(WIDTH); no wrap past WIDTH-1 in RUN.
//   Reset mid-RUN: operation aborted, no done pulse, outputs to reset values.
//   Outputs registered; no combinational path from inputs to outputs.
// TESTING
//   T1 WIDTH=4, a=0,b=0,cin=0, start 1 cycle -> busy 4 cycles, done pulse
//      4 cycles after accept, sum=0000, cout=0.
//   T2 WIDTH=4, a=1001,b=1000,cin=0 -> sum=0001, cout=1; a=0111,b=0001,cin=0
//      -> sum=1000, cout=0 (full ripple of carry through three bits).
//   T3 WIDTH=4, a=1111,b=1111,cin=1 -> sum=1111, cout=1; then a=0,b=0,cin=0
//      -> sum/cout hold 1111/1 until second done, then 0000/0.
//   T4 start held high continuously with changing a/b -> only IDLE-cycle
//      starts accepted, one done per WIDTH+2 cycles, results match captured ops.
//   T5 rst pulse at 2nd RUN cycle of a=0101,b=0011 -> busy=0, sum=0, cout=0
//      immediately, no done; next start a=0101,b=0011 -> sum=1000, cout=0.
//   T6 WIDTH=8, a=200,b=100,cin=0 -> busy 8 cycles, sum=44, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH clocks, LSB first.
// Start/busy/done handshake; sum/cout are held until the next completion.
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic s_bit;
    logic c_next;

    // The single shared full-adder cell, fed by the operand LSBs and the carry flop.
    assign s_bit  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign c_next = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = c_next;
                if (cnt_q == LAST) begin
                    // Final bit: publish the completed result on the same edge.
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Outputs decode or mirror flops only; nothing combinational from the inputs.
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: WIDTH=4 and WIDTH=8 instances, hand-computed results.
module tb_serial_add_ctrl;
    logic       clk;
    logic       rst;
    logic       start4, busy4, done4, cin4, cout4;
    logic [3:0] a4, b4, sum4;
    logic       start8, busy8, done8, cin8, cout8;
    logic [7:0] a8, b8, sum8;

    int n_tests;
    int n_fail;
    logic [4:0] exp_q[$];
    logic [4:0] prev_res;
    logic [4:0] exp_res;

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=4 operation from IDLE: busy for 4 cycles with the previous result held,
    // then a one-cycle done with the new result, then back to IDLE.
    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                           input logic [4:0] expect_res);
        a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~ta; b4 = ~tb; cin4 = ~tc;
        for (int i = 0; i < 4; i++) begin
            check("run_busy", busy4, 1'b1);
            check("run_nodone", done4, 1'b0);
            check("run_hold", {cout4, sum4}, prev_res);
            tick();
        end
        check("done_pulse", done4, 1'b1);
        check("done_notbusy", busy4, 1'b0);
        check("result", {cout4, sum4}, expect_res);
        tick();
        check("done_clear", done4, 1'b0);
        check("idle_notbusy", busy4, 1'b0);
        check("idle_hold", {cout4, sum4}, expect_res);
        prev_res = expect_res;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev_res = 5'd0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        tick();
        tick();
        check("reset_busy", busy4, 1'b0);
        check("reset_done", done4, 1'b0);
        check("reset_result", {cout4, sum4}, 5'd0);
        check("reset_busy8", busy8, 1'b0);
        check("reset_result8", {cout8, sum8}, 9'd0);
        rst = 1'b0;
        tick();
        check("idle_no_start", busy4, 1'b0);

        // T1..T3
        run_op4(4'b0000, 4'b0000, 1'b0, 5'b0_0000);
        run_op4(4'b1001, 4'b1000, 1'b0, 5'b1_0001);
        run_op4(4'b0111, 4'b0001, 1'b0, 5'b0_1000);
        run_op4(4'b1111, 4'b1111, 1'b1, 5'b1_1111);
        run_op4(4'b0000, 4'b0000, 1'b0, 5'b0_0000);

        // T4: start held high; only the IDLE-cycle operands are captured.
        for (int c = 0; c < 18; c++) begin
            logic [3:0] va, vb;
            logic       vc;
            int         p;
            p  = c % 6;
            va = 4'((c * 5 + 3) & 15);
            vb = 4'((c * 7 + 1) & 15);
            vc = c[0];
            a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
            if (p == 0) exp_q.push_back(5'(va) + 5'(vb) + 5'(vc));
            tick();
            check("hold_busy", busy4, (p <= 3) ? 1'b1 : 1'b0);
            check("hold_done", done4, (p == 4) ? 1'b1 : 1'b0);
            if (p == 4) begin
                if (exp_q.size() == 0) begin
                    check("hold_queue_empty", 32'd1, 32'd0);
                end else begin
                    exp_res = exp_q.pop_front();
                    check("hold_result", {cout4, sum4}, exp_res);
                    prev_res = exp_res;
                end
            end
        end
        start4 = 1'b0;
        check("hold_queue_drained", exp_q.size(), 0);
        tick();
        check("hold_idle", busy4, 1'b0);

        // T5: reset in the second RUN cycle aborts, then a clean rerun.
        a4 = 4'b0101; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("pre_abort_busy", busy4, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy4, 1'b0);
        check("abort_done", done4, 1'b0);
        check("abort_result", {cout4, sum4}, 5'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("abort_no_done", done4, 1'b0);
        end
        prev_res = 5'd0;
        run_op4(4'b0101, 4'b0011, 1'b0, 5'b0_1000);

        // T6: WIDTH=8, 200 + 100 = 300 -> sum 44, cout 1.
        a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'd0; b8 = 8'd0;
        for (int i = 0; i < 8; i++) begin
            check("w8_busy", busy8, 1'b1);
            check("w8_nodone", done8, 1'b0);
            tick();
        end
        check("w8_done", done8, 1'b1);
        check("w8_notbusy", busy8, 1'b0);
        check("w8_sum", sum8, 8'd44);
        check("w8_cout", cout8, 1'b1);
        tick();
        check("w8_done_clear", done8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
